branch_ctrl_unit: RTL and testbench
===================================

Name: branch_ctrl_unit

Overview:
- Parametrised, stateful successor to the combinational control decoder. It sits between instruction fetch/decode and the program counter.
- Owns the architectural condition-flag and overflow registers.
- Resolves conditional branches (taken-if-set / taken-if-clear) against the registered flag.
- Sequences post-branch flush bubbles and a terminal HALT state.
- Counts taken branches for performance monitoring.

Parameters:
- IW, 9, instruction width; opcode is Instruction[IW-1:IW-OPW], function is Instruction[FNW-1:0].
- OPW, 3, opcode field width.
- FNW, 3, function field width.
- FLUSH_CYC, 1, bubble cycles after a taken branch; legal range 0..7.
- CNTW, 16, taken-branch counter width.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Instruction  in  IW  current machine code.
- instr_valid  in  1  Instruction is a real instruction this cycle.
- cmp_flag  in  1  ALU compare result, used by CEQ/CLT.
- alu_ovf  in  1  ALU overflow/carry-out for the current instruction.
- branch_en  out  1  take branch this cycle; combinational.
- flush  out  1  fetch/decode must squash the current instruction.
- halted  out  1  core is stopped.
- flag_q  out  1  registered condition flag.
- ovf_q  out  1  registered overflow flag.
- br_count  out  CNTW  saturating count of taken branches.

Behaviour:
- Reset: state=RUN, flag_q=0, ovf_q=0, br_count=0, flush counter=0. Therefore branch_en=0, flush=0, halted=0. Reset wins over every other event in the same cycle, including mid-flush and HALT.
- An instruction is "live" when instr_valid=1 and state=RUN. Outside that condition, no register writes and branch_en=0.
- Flag write: on a live opCEQ or opCLT, flag_q<=cmp_flag at the next edge.
- Overflow write, at the next edge, ovf_q<=alu_ovf when:
  - a live opADD or opSUB, or
  - a live opOTHER whose function is not fnB0, fnB1 or fnHALT.
- All other instructions hold flag_q and ovf_q.
- Branch, combinational with zero latency:
  - branch_en=1 for a live opOTHER with fn=fnB0 and flag_q=1.
  - branch_en=1 for a live opOTHER with fn=fnB1 and flag_q=0.
  - The flag is never bypassed. A CEQ at cycle N affects a branch at cycle N+1 onward.
- FSM states: RUN, FLUSH, HALT.
  - RUN -> FLUSH: branch_en=1 and FLUSH_CYC>0. Counter is loaded with FLUSH_CYC-1.
  - RUN -> RUN: branch_en=1 and FLUSH_CYC=0; no bubble is generated.
  - RUN -> HALT: live opOTHER with fn=fnHALT. A halt instruction never branches and never writes flags.
  - FLUSH: flush=1 every cycle. Counter decrements; when it is 0, go to RUN at the next edge. FLUSH lasts exactly FLUSH_CYC cycles. Instructions in FLUSH are ignored, including branches and HALT.
  - HALT: halted=1 and flush=1. Remains until Reset.
- br_count increments by 1 on each cycle with branch_en=1. It saturates at 2^CNTW-1 and does not wrap.
- instr_valid=0 in RUN: pure hold; the FSM stays in RUN.
- Undefined opcodes: no writes, no branch.

Decomposition:
- Package definitions: opcode constants opADD, opSUB, opCEQ, opCLT, opOTHER.
- Package definitions: function constants fnB0, fnB1, and new fnHALT.
- Package definitions: enum ctrl_state_t {RUN, FLUSH, HALT}.
- One natural sub-module: sat_counter, parametrised by width, with inc and clear inputs, used for br_count.
- Decode, FSM and flag registers stay in branch_ctrl_unit.

Test Plan:
- Reset mid-flush: FLUSH_CYC=3, take a branch, assert Reset during the 2nd bubble -> next cycle state=RUN, flush=0, br_count=0, flag_q=0.
- Flag then branch: CEQ with cmp_flag=1, then B0 -> branch_en=1 on the B0 cycle. flush=1 for exactly FLUSH_CYC=1 cycle. br_count=1.
- Clear-branch: CLT with cmp_flag=0, then B1 -> branch_en=1. Separately, CLT with cmp_flag=1, then B1 -> branch_en=0 and no flush.
- Overflow write: ADD with alu_ovf=1 -> ovf_q=1. opOTHER fnB0 with alu_ovf=0 -> ovf_q stays 1. SUB with alu_ovf=0 -> ovf_q=0.
- Flush squash and halt: during FLUSH present CEQ (cmp_flag=1, flag_q=0) and fnHALT -> flag_q stays 0, no HALT. Later, a live fnHALT -> halted=1 held for 10 cycles, ignoring instructions, until Reset.
- Saturation: CNTW=4, 20 taken branches with FLUSH_CYC=0 -> br_count reaches 15 and stays 15.

Source files
------------

// File: rtl/branch_ctrl_unit_pkg.sv
// Shared encodings for the branch control unit: opcode/function constants,
// FSM state type and default field widths.
package branch_ctrl_unit_pkg;

  localparam int IW_DEF   = 9;
  localparam int CNTW_DEF = 16;

  localparam logic [2:0] opADD   = 3'b000;
  localparam logic [2:0] opSUB   = 3'b001;
  localparam logic [2:0] opCEQ   = 3'b010;
  localparam logic [2:0] opCLT   = 3'b011;
  localparam logic [2:0] opOTHER = 3'b111;

  localparam logic [2:0] fnB0   = 3'b000;
  localparam logic [2:0] fnB1   = 3'b001;
  localparam logic [2:0] fnHALT = 3'b111;

  typedef enum logic [1:0] {RUN, FLUSH, HALT} ctrl_state_t;

endpackage

// File: rtl/branch_ctrl_unit_if.sv
// Instruction-side inputs and control/status outputs of the branch control unit.
interface branch_ctrl_unit_if
  import branch_ctrl_unit_pkg::*;
#(
  parameter int IW   = IW_DEF,
  parameter int CNTW = CNTW_DEF
);
  logic [IW-1:0]   Instruction;
  logic            instr_valid;
  logic            cmp_flag;
  logic            alu_ovf;
  logic            branch_en;
  logic            flush;
  logic            halted;
  logic            flag_q;
  logic            ovf_q;
  logic [CNTW-1:0] br_count;

  modport master (
    output Instruction, instr_valid, cmp_flag, alu_ovf,
    input  branch_en, flush, halted, flag_q, ovf_q, br_count
  );

  modport slave (
    input  Instruction, instr_valid, cmp_flag, alu_ovf,
    output branch_en, flush, halted, flag_q, ovf_q, br_count
  );
endinterface

// File: rtl/branch_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (clear)                   count <= '0;
    else if (inc && count != '1) count <= count + W'(1);
  end
endmodule

// File: rtl/branch_ctrl_unit.sv
// Branch resolution, flag/overflow registers, flush/halt sequencing and
// taken-branch counting between decode and the program counter.
module branch_ctrl_unit
  import branch_ctrl_unit_pkg::*;
#(
  parameter int IW        = 9,
  parameter int OPW       = 3,
  parameter int FNW       = 3,
  parameter int FLUSH_CYC = 1,
  parameter int CNTW      = 16
) (
  input logic              Clk,
  input logic              Reset,
  branch_ctrl_unit_if.slave bus
);
  ctrl_state_t    state, state_d;
  logic [2:0]     cnt, cnt_d;
  logic           flag_r, ovf_r;
  logic [OPW-1:0] opc;
  logic [FNW-1:0] fn;
  logic           live, is_other, fn_b0, fn_b1, fn_halt;
  logic           br_take, is_halt, flag_we, ovf_we;

  assign opc = bus.Instruction[IW-1 -: OPW];
  assign fn  = bus.Instruction[FNW-1:0];

  always_comb begin
    live     = bus.instr_valid && (state == RUN);
    is_other = (opc == OPW'(opOTHER));
    fn_b0    = (fn == FNW'(fnB0));
    fn_b1    = (fn == FNW'(fnB1));
    fn_halt  = (fn == FNW'(fnHALT));
    // Branch uses only the registered flag; there is no bypass from cmp_flag.
    br_take  = live && is_other && ((fn_b0 && flag_r) || (fn_b1 && !flag_r));
    is_halt  = live && is_other && fn_halt;
    flag_we  = live && ((opc == OPW'(opCEQ)) || (opc == OPW'(opCLT)));
    ovf_we   = live && ((opc == OPW'(opADD)) || (opc == OPW'(opSUB)) ||
                        (is_other && !fn_b0 && !fn_b1 && !fn_halt));
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      RUN: begin
        if (is_halt) begin
          state_d = HALT;
        end else if (br_take && (FLUSH_CYC > 0)) begin
          state_d = FLUSH;
          cnt_d   = 3'(FLUSH_CYC - 1);
        end
      end
      FLUSH: begin
        if (cnt == '0) state_d = RUN;
        else           cnt_d   = cnt - 3'd1;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= RUN;
      cnt    <= '0;
      flag_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (flag_we) flag_r <= bus.cmp_flag;
      if (ovf_we)  ovf_r  <= bus.alu_ovf;
    end
  end

  sat_counter #(.W(CNTW)) u_br_cnt (
    .clk   (Clk),
    .clear (Reset),
    .inc   (br_take),
    .count (bus.br_count)
  );

  assign bus.branch_en = br_take;
  assign bus.flush     = (state != RUN);
  assign bus.halted    = (state == HALT);
  assign bus.flag_q    = flag_r;
  assign bus.ovf_q     = ovf_r;
endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Scoreboard bench: three configurations (FLUSH_CYC 1/3/0, CNTW 16/16/4)
// driven with directed vectors; a negedge monitor pops and compares.
module tb_branch_ctrl_unit;
  import branch_ctrl_unit_pkg::*;

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;
  always #5 clk = ~clk;

  branch_ctrl_unit_if #(.IW(9), .CNTW(16)) if0 ();
  branch_ctrl_unit_if #(.IW(9), .CNTW(16)) if1 ();
  branch_ctrl_unit_if #(.IW(9), .CNTW(4))  if2 ();

  branch_ctrl_unit #(.IW(9), .OPW(3), .FNW(3), .FLUSH_CYC(1), .CNTW(16))
    u0 (.Clk(clk), .Reset(rst[0]), .bus(if0));
  branch_ctrl_unit #(.IW(9), .OPW(3), .FNW(3), .FLUSH_CYC(3), .CNTW(16))
    u1 (.Clk(clk), .Reset(rst[1]), .bus(if1));
  branch_ctrl_unit #(.IW(9), .OPW(3), .FNW(3), .FLUSH_CYC(0), .CNTW(4))
    u2 (.Clk(clk), .Reset(rst[2]), .bus(if2));

  // exp/msk bit order: {branch_en, flush, halted, flag_q, ovf_q}; cnt < 0 = unchecked
  typedef struct {
    int         dut;
    string      nm;
    logic [4:0] exp;
    logic [4:0] msk;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [8:0] mk(input logic [2:0] op, input logic [2:0] f);
    return {op, 3'b000, f};
  endfunction

  task automatic step(input int d, input logic r, input logic [8:0] ins,
                      input logic v, input logic c, input logic o,
                      input string nm, input logic [4:0] e, input logic [4:0] m,
                      input int cnt);
    @(posedge clk);
    #1;
    rst[d] = r;
    case (d)
      0: begin if0.Instruction = ins; if0.instr_valid = v; if0.cmp_flag = c; if0.alu_ovf = o; end
      1: begin if1.Instruction = ins; if1.instr_valid = v; if1.cmp_flag = c; if1.alu_ovf = o; end
      default: begin if2.Instruction = ins; if2.instr_valid = v; if2.cmp_flag = c; if2.alu_ovf = o; end
    endcase
    if (m != 5'b0 || cnt >= 0) sb.push_back('{d, nm, e, m, cnt});
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [4:0]  act;
      logic [15:0] acnt;
      e = sb.pop_front();
      case (e.dut)
        0: begin act = {if0.branch_en, if0.flush, if0.halted, if0.flag_q, if0.ovf_q}; acnt = if0.br_count; end
        1: begin act = {if1.branch_en, if1.flush, if1.halted, if1.flag_q, if1.ovf_q}; acnt = if1.br_count; end
        default: begin act = {if2.branch_en, if2.flush, if2.halted, if2.flag_q, if2.ovf_q}; acnt = 16'(if2.br_count); end
      endcase
      if (e.msk != 5'b0) begin
        n_cmp++;
        if ((act & e.msk) !== (e.exp & e.msk)) begin
          n_bad++;
          $display("FAIL %s dut%0d {br,flush,halt,flag,ovf} got %b want %b (mask %b)",
                   e.nm, e.dut, act, e.exp, e.msk);
        end
      end
      if (e.cnt >= 0) begin
        n_cmp++;
        if (acnt !== 16'(e.cnt)) begin
          n_bad++;
          $display("FAIL %s dut%0d br_count got %0d want %0d", e.nm, e.dut, acnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [4:0] ALL = 5'h1F;

  initial begin
    logic [8:0] NOP, CEQ, CLT, ADD, SUB, B0, B1, HLT, OTH, UND;
    NOP = mk(opADD, 3'b000);
    CEQ = mk(opCEQ, 3'b000);
    CLT = mk(opCLT, 3'b000);
    ADD = mk(opADD, 3'b000);
    SUB = mk(opSUB, 3'b000);
    B0  = mk(opOTHER, fnB0);
    B1  = mk(opOTHER, fnB1);
    HLT = mk(opOTHER, fnHALT);
    OTH = mk(opOTHER, 3'b010);
    UND = mk(3'b100, 3'b000);
    {if0.Instruction, if0.instr_valid, if0.cmp_flag, if0.alu_ovf} = '0;
    {if1.Instruction, if1.instr_valid, if1.cmp_flag, if1.alu_ovf} = '0;
    {if2.Instruction, if2.instr_valid, if2.cmp_flag, if2.alu_ovf} = '0;

    // FLUSH_CYC = 1
    step(0, 1, NOP, 0, 0, 0, "rst0",        5'b00000, 5'b0, -1);
    step(0, 0, NOP, 0, 0, 0, "reset_state", 5'b00000, ALL, 0);
    step(0, 0, CEQ, 1, 1, 0, "ceq_no_byp",  5'b00000, ALL, 0);
    step(0, 0, B0,  1, 0, 0, "b0_taken",    5'b10010, ALL, 0);
    step(0, 0, CEQ, 1, 0, 0, "bubble_sq",   5'b01010, ALL, 1);
    step(0, 0, NOP, 0, 0, 0, "flush_1cyc",  5'b00010, ALL, 1);
    step(0, 0, CLT, 1, 0, 0, "clt0",        5'b00010, ALL, 1);
    step(0, 0, B1,  1, 0, 0, "b1_taken",    5'b10000, ALL, 1);
    step(0, 0, NOP, 0, 0, 0, "b1_bubble",   5'b01000, ALL, 2);
    step(0, 0, CLT, 1, 1, 0, "clt1",        5'b00000, ALL, 2);
    step(0, 0, B1,  1, 0, 0, "b1_not",      5'b00010, ALL, 2);
    step(0, 0, NOP, 0, 0, 0, "no_flush",    5'b00010, ALL, 2);
    step(0, 0, ADD, 1, 0, 1, "add_ovf1",    5'b00010, ALL, 2);
    step(0, 0, B0,  1, 0, 0, "b0_keep_ovf", 5'b10011, ALL, 2);
    step(0, 0, NOP, 0, 0, 0, "b0_bubble",   5'b01011, ALL, 3);
    step(0, 0, SUB, 1, 0, 0, "sub_ovf0",    5'b00011, ALL, 3);
    step(0, 0, NOP, 0, 0, 0, "sub_result",  5'b00010, ALL, 3);
    step(0, 0, OTH, 1, 0, 1, "oth_ovf1",    5'b00010, ALL, 3);
    step(0, 0, UND, 1, 0, 0, "undef_op",    5'b00011, ALL, 3);
    step(0, 0, CEQ, 0, 0, 0, "invalid_ceq", 5'b00011, ALL, 3);
    step(0, 0, NOP, 0, 0, 0, "hold",        5'b00011, ALL, 3);
    step(0, 0, CEQ, 1, 0, 0, "ceq0",        5'b00011, ALL, 3);
    step(0, 0, B1,  1, 0, 0, "b1_again",    5'b10001, ALL, 3);
    step(0, 0, CEQ, 1, 1, 0, "flush_ceq",   5'b01001, ALL, 4);
    step(0, 0, B1,  1, 0, 0, "b1_flag_kept",5'b10001, ALL, 4);
    step(0, 0, HLT, 1, 0, 0, "flush_halt",  5'b01001, ALL, 5);
    step(0, 0, NOP, 0, 0, 0, "no_halt",     5'b00001, ALL, 5);
    step(0, 0, HLT, 1, 0, 0, "halt_instr",  5'b00001, ALL, 5);
    for (int i = 0; i < 10; i++) begin
      logic [8:0] ins;
      ins = (i % 3 == 0) ? B1 : ((i % 3 == 1) ? CEQ : ADD);
      step(0, 0, ins, 1, 1, 0, "halted_hold", 5'b01101, ALL, 5);
    end
    step(0, 1, NOP, 0, 0, 0, "halt_rst",    5'b01101, ALL, 5);
    step(0, 0, NOP, 0, 0, 0, "post_rst",    5'b00000, ALL, 0);

    // FLUSH_CYC = 3, reset during the second bubble
    step(1, 1, NOP, 0, 0, 0, "rst1",        5'b00000, 5'b0, -1);
    step(1, 0, NOP, 0, 0, 0, "reset1",      5'b00000, ALL, 0);
    step(1, 0, CEQ, 1, 1, 0, "ceq1",        5'b00000, ALL, 0);
    step(1, 0, B0,  1, 0, 0, "b0_fc3",      5'b10010, ALL, 0);
    for (int i = 0; i < 3; i++) step(1, 0, B0, 1, 0, 0, "bubble3", 5'b01010, ALL, 1);
    step(1, 0, NOP, 0, 0, 0, "fc3_done",    5'b00010, ALL, 1);
    step(1, 0, B0,  1, 0, 0, "b0_fc3_2",    5'b10010, ALL, 1);
    step(1, 0, NOP, 0, 0, 0, "bubble_a",    5'b01010, ALL, 2);
    step(1, 1, NOP, 0, 0, 0, "bubble_b_rst",5'b01010, ALL, 2);
    step(1, 0, NOP, 0, 0, 0, "midflush_rst",5'b00000, ALL, 0);
    step(1, 0, NOP, 0, 0, 0, "stay_run",    5'b00000, ALL, 0);

    // FLUSH_CYC = 0, CNTW = 4 saturation
    step(2, 1, NOP, 0, 0, 0, "rst2",        5'b00000, 5'b0, -1);
    step(2, 0, NOP, 0, 0, 0, "reset2",      5'b00000, ALL, 0);
    step(2, 0, CEQ, 1, 1, 0, "ceq2",        5'b00000, ALL, 0);
    for (int i = 0; i < 20; i++)
      step(2, 0, B0, 1, 0, 0, "sat_branch", 5'b10010, ALL, (i < 15) ? i : 15);
    step(2, 0, NOP, 0, 0, 0, "sat_hold",    5'b00010, ALL, 15);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
